mash11_dsm: RTL and testbench
=============================

MASH11_DSM -- requirements
Module: mash11_dsm

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input sample width and accumulator width.
REQ-002 SHALL have parameter OSR_LOG2, default 5: log2 of modulator cycles per input sample (OSR = 2**OSR_LOG2).
REQ-003 SHALL have port aclk  in  1: clock; all logic on rising edge.
REQ-004 SHALL have port arst_n  in  1: reset, synchronous, active-low; clock aclk.
REQ-005 SHALL have port s_axis_data_tdata  in  WIDTH: signed two's-complement input sample.
REQ-006 SHALL have ports s_axis_data_tvalid  in  1 and s_axis_data_tready  out  1: AXI-Stream input handshake.
REQ-007 SHALL have port m_axis_data_tdata  out  3: signed output level in {-1,0,1,2}.
REQ-008 SHALL have port m_axis_data_tvalid  out  1: output level valid; no back-pressure.
REQ-009 SHALL have port underrun  out  1: one-cycle pulse on a missed input sample.

Function
REQ-010 SHALL hold a one-entry input buffer (buf, buf_valid) and a hold register (hold) feeding the modulator.
REQ-011 SHALL drive s_axis_data_tready = ~buf_valid | tick, where tick = (state==RUN && cnt==OSR-1).
REQ-012 SHALL capture tdata into buf with buf_valid<=1 on tvalid&tready; simultaneous capture and tick SHALL keep buf_valid=1.
REQ-013 SHALL implement states IDLE and RUN; IDLE->RUN on the first accepted sample, which loads directly into hold with cnt<=0.
REQ-014 SHALL increment cnt (OSR_LOG2 bits, wrapping) every RUN cycle; at tick, SHALL load hold<=buf and clear buf_valid when buf_valid=1.
REQ-015 SHALL, at tick with buf_valid=0 and no simultaneous capture, keep hold unchanged and pulse underrun for one cycle.
REQ-016 SHALL convert hold to offset binary u = {~hold[WIDTH-1], hold[WIDTH-2:0]}.
REQ-017 SHALL, each RUN cycle, compute stage 1 as {c1,acc1} <= acc1 + u + cin (WIDTH-bit unsigned, carry out c1).
REQ-018 SHALL, each RUN cycle, compute stage 2 as {c2,acc2} <= acc2 + acc1_next (acc1_next = new stage-1 residue).
REQ-019 SHALL register m_axis_data_tdata <= c1 + c2 - c2_d (c2_d = c2 of the previous RUN cycle, 3-bit signed), one cycle after the accumulator update.
REQ-020 SHALL assert m_axis_data_tvalid one cycle after entering RUN and keep it high while in RUN.
REQ-021 SHALL freeze accumulators and output 0 with tvalid=0 in IDLE; RUN never returns to IDLE except through reset.
REQ-022 SHALL satisfy, over any N consecutive RUN outputs, sum = sum(c1) + c2_last - c2_first_prev (telescoping noise cancellation).

Reset
REQ-023 SHALL, with arst_n=0 at a clock edge, set state=IDLE, cnt=0, acc1=acc2=0, c2_d=0, hold=0, buf_valid=0, m_axis_data_tdata=0, m_axis_data_tvalid=0, underrun=0; reset overrides all concurrent events.
REQ-024 SHALL present s_axis_data_tready=1 during and immediately after reset.

Configuration
REQ-025 SHALL, with MASH11_DITHER_EN defined, drive cin from bit 0 of a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advancing each RUN cycle.
REQ-026 SHALL, without MASH11_DITHER_EN, tie cin=0 and contain no LFSR logic.

Structure
REQ-027 SHALL take the output level typedef (3-bit signed), state enum, LFSR seed and tap constants from package mash_pkg.
REQ-028 SHALL build each stage from one sub-module dsm_acc_stage (WIDTH-bit accumulator, registered residue and carry out), instantiated twice.

Verification
REQ-029 SHALL check reset: after arst_n low for 2 cycles -> tdata=0, m_tvalid=0, tready=1, underrun=0.
REQ-030 SHALL check mid-scale: tdata=16'sh0000 always valid, dither off, OSR_LOG2=5 -> every output in {-1..2} and the sum of 1024 outputs is in [511,513].
REQ-031 SHALL check full-scale: tdata=16'sh7FFF -> the sum of 65536 outputs is in [65534,65536]; tdata=16'sh8000 -> sum in [-1,1].
REQ-032 SHALL check handshake: tvalid held high -> exactly one transfer every 32 cycles after the first, and no underrun.
REQ-033 SHALL check underrun: one sample then tvalid=0 -> underrun pulses every 32 cycles, hold is retained, and m_tvalid stays 1; reset mid-RUN -> outputs 0 and IDLE on the next cycle.

Source files
------------

// File: rtl/mash_pkg.sv
// ============================================================================
// Module : mash_pkg
// Shared types and constants for the MASH 1-1 delta-sigma modulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mash_pkg;

    // Output level of the two-stage MASH: range {-1, 0, 1, 2}
    typedef logic signed [2:0] level_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'h002D;

endpackage

`default_nettype wire

// File: rtl/dsm_acc_stage.sv
// ============================================================================
// Module : dsm_acc_stage
// One first-order accumulator stage: registered residue and carry out, with
// the not-yet-registered residue exposed for chaining into the next stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dsm_acc_stage #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_add,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_add} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum   = w_sum[WIDTH-1:0];
    assign o_carry = r_carry;

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (i_en) begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_carry <= w_sum[WIDTH];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mash11_dsm.sv
// ============================================================================
// Module : mash11_dsm
// MASH 1-1 delta-sigma modulator with AXI-Stream sample input, one-entry
// buffer and underrun flag. Define MASH11_DITHER_EN for LFSR carry-in dither.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mash11_dsm #(
    parameter int WIDTH    = 16,
    parameter int OSR_LOG2 = 5
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [2:0]       m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    output logic             underrun
);

    import mash_pkg::*;

    localparam logic [OSR_LOG2-1:0] c_cnt_last = '1;
    localparam logic [OSR_LOG2-1:0] c_cnt_one  = 1;

    state_t              r_state;
    logic [OSR_LOG2-1:0] r_cnt;
    logic [WIDTH-1:0]    r_buf;
    logic                r_buf_valid;
    logic [WIDTH-1:0]    r_hold;
    logic                r_underrun;
    logic                r_c2_d;
    level_t              r_level;
    logic                r_m_tvalid;

    logic                w_run;
    logic                w_tick;
    logic                w_accept;
    logic                w_cin;
    logic [WIDTH-1:0]    w_u;
    level_t              w_level;

    logic [WIDTH-1:0]    w_add   [2];
    logic                w_cin_s [2];
    logic [WIDTH-1:0]    w_sum   [2];
    logic                w_carry [2];

    assign w_run              = (r_state == ST_RUN);
    assign w_tick             = w_run && (r_cnt == c_cnt_last);
    assign s_axis_data_tready = ~r_buf_valid | w_tick;
    assign w_accept           = s_axis_data_tvalid & s_axis_data_tready;

    // Sample sequencing: hold feeds the modulator, buf stages the next sample
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_hold      <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hold  <= s_axis_data_tdata;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (w_tick && r_buf_valid) begin
                        r_hold      <= r_buf;
                        r_buf_valid <= 1'b0;
                    end
                    if (w_tick && !r_buf_valid && !w_accept) begin
                        r_underrun <= 1'b1;
                    end
                    // A capture on the tick edge overrides the clear above
                    if (w_accept) begin
                        r_buf       <= s_axis_data_tdata;
                        r_buf_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MASH11_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_run) begin
            r_lfsr <= {^(r_lfsr & c_lfsr_taps), r_lfsr[15:1]};
        end
    end

    assign w_cin = r_lfsr[0];
`else
    assign w_cin = 1'b0;
`endif

    assign w_u        = {~r_hold[WIDTH-1], r_hold[WIDTH-2:0]};
    assign w_add[0]   = w_u;
    assign w_add[1]   = w_sum[0];
    assign w_cin_s[0] = w_cin;
    assign w_cin_s[1] = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_stage
        dsm_acc_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .aclk    (aclk),
            .arst_n  (arst_n),
            .i_en    (w_run),
            .i_add   (w_add[g]),
            .i_cin   (w_cin_s[g]),
            .o_sum   (w_sum[g]),
            .o_carry (w_carry[g])
        );
    end

    // Stage-2 carry is differentiated so its noise cancels over time
    assign w_level = $signed({2'b00, w_carry[0]}) + $signed({2'b00, w_carry[1]})
                   - $signed({2'b00, r_c2_d});

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_c2_d     <= 1'b0;
            r_level    <= '0;
            r_m_tvalid <= 1'b0;
        end else if (w_run) begin
            r_c2_d     <= w_carry[1];
            r_level    <= w_level;
            r_m_tvalid <= 1'b1;
        end else begin
            r_level    <= '0;
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_data_tdata  = r_level;
    assign m_axis_data_tvalid = r_m_tvalid;
    assign underrun           = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_mash11_dsm.sv
// ============================================================================
// Module : tb_mash11_dsm
// Self-checking bench for mash11_dsm (default build, dither disabled).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mash11_dsm;

    localparam int WIDTH    = 16;
    localparam int OSR_LOG2 = 5;

    logic              aclk   = 1'b0;
    logic              arst_n = 1'b0;
    logic [WIDTH-1:0]  s_tdata  = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [2:0]        m_tdata;
    logic              m_tvalid;
    logic              ur;

    always #5 aclk = ~aclk;

    mash11_dsm #(
        .WIDTH    (WIDTH),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .underrun           (ur)
    );

    typedef struct {
        logic [15:0] data;
        int          n_out;
        int          n_model;
        int          lo;
        int          hi;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        arst_n   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        step();
        step();
        arst_n = 1'b1;
    endtask

    // Reference MASH 1-1 for a constant sample; first output is the reset residue
    task automatic push_model(input logic [15:0] sample, input int n);
        int a1 = 0, a2 = 0, p2 = 0, u, s1, s2, c1, c2;
        u = int'({~sample[15], sample[14:0]});
        exp_q.push_back(0);
        for (int k = 1; k < n; k++) begin
            s1 = a1 + u;
            c1 = (s1 >= 65536) ? 1 : 0;
            a1 = s1 % 65536;
            s2 = a2 + a1;
            c2 = (s2 >= 65536) ? 1 : 0;
            a2 = s2 % 65536;
            exp_q.push_back(c1 + c2 - p2);
            p2 = c2;
        end
    endtask

    task automatic run_const(input int idx, input vec_t v);
        int cnt = 0, sum = 0, n_ur = 0, bad = 0, cyc = 0, lvl;
        do_reset();
        exp_q.delete();
        push_model(v.data, v.n_model);
        s_tdata  = v.data;
        s_tvalid = 1'b1;
        while (cnt < v.n_out && cyc < v.n_out + 200) begin
            step();
            cyc++;
            if (ur) n_ur++;
            if (m_tvalid) begin
                lvl = int'($signed(m_tdata));
                if (lvl < -1 || lvl > 2) bad++;
                sum += lvl;
                if (exp_q.size() > 0)
                    check($sformatf("v%0d_out%0d", idx, cnt), lvl, exp_q.pop_front());
                cnt++;
            end
        end
        s_tvalid = 1'b0;
        check($sformatf("v%0d_count", idx), cnt, v.n_out);
        check_range($sformatf("v%0d_sum", idx), sum, v.lo, v.hi);
        check($sformatf("v%0d_level_range", idx), bad, 0);
        check($sformatf("v%0d_underrun", idx), n_ur, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   xfer[$];
        int   urc[$];
        int   exp_x[8];
        int   n_ur, nv, lvl;

        vecs[0] = '{16'h0000, 1024,  64, 511,   513};
        vecs[1] = '{16'h7FFF, 65536, 64, 65534, 65536};
        vecs[2] = '{16'h8000, 1024,  64, -1,    1};
        vecs[3] = '{16'h4000, 256,  256, 190,   193};
        vecs[4] = '{16'hC000, 256,  256, 62,    65};

        // Reset state
        do_reset();
        arst_n = 1'b0;
        step();
        step();
        check("rst_tdata", int'(m_tdata), 0);
        check("rst_tvalid", int'(m_tvalid), 0);
        check("rst_tready", int'(s_tready), 1);
        check("rst_underrun", int'(ur), 0);
        arst_n = 1'b1;
        step();
        check("post_rst_tready", int'(s_tready), 1);
        check("post_rst_tvalid", int'(m_tvalid), 0);

        for (int i = 0; i < 5; i++) run_const(i, vecs[i]);

        // Handshake: tvalid held high; hold fill, buffer fill, then one per tick
        exp_x = '{0, 1, 32, 64, 96, 128, 160, 192};
        do_reset();
        s_tdata  = 16'h1234;
        s_tvalid = 1'b1;
        n_ur     = 0;
        for (int c = 0; c < 200; c++) begin
            if (s_tvalid && s_tready) xfer.push_back(c);
            step();
            if (ur) n_ur++;
        end
        s_tvalid = 1'b0;
        check("hs_xfer_count", xfer.size(), 8);
        for (int k = 0; k < 8 && k < xfer.size(); k++)
            check($sformatf("hs_xfer%0d_cycle", k), xfer[k], exp_x[k]);
        check("hs_underrun", n_ur, 0);

        // Underrun: a single sample, then starvation
        do_reset();
        exp_q.delete();
        push_model(16'h4000, 140);
        s_tdata  = 16'h4000;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tdata  = 16'hFFFF;
        nv       = 0;
        for (int c = 1; c <= 140; c++) begin
            step();
            if (ur) urc.push_back(c);
            if (!m_tvalid) begin
                nv++;
            end else begin
                lvl = int'($signed(m_tdata));
                if (exp_q.size() > 0)
                    check($sformatf("ur_out%0d", c), lvl, exp_q.pop_front());
            end
        end
        check("ur_tvalid_drop", nv, 0);
        check("ur_model_left", exp_q.size(), 0);
        check("ur_pulse_count", urc.size(), 4);
        for (int k = 0; k < 4 && k < urc.size(); k++)
            check($sformatf("ur_pulse%0d_cycle", k), urc[k], 32 * (k + 1));

        // Reset in the middle of RUN
        arst_n = 1'b0;
        step();
        check("midrst_tdata", int'(m_tdata), 0);
        check("midrst_tvalid", int'(m_tvalid), 0);
        check("midrst_underrun", int'(ur), 0);
        check("midrst_tready", int'(s_tready), 1);
        arst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (m_tvalid || m_tdata != 3'd0 || ur) nv++;
        end
        check("midrst_idle_quiet", nv, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
